mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter sharing the single-port BlockRam memory bus between the DijkstraTop core (requester 0) and the host/graph loader (requester 1).
- Replaces the tristate bus sharing with a registered, transaction-level grant.
- Round-robin fairness, one memory transaction per grant.
- Watchdog releases a requester whose transaction never completes.

Parameters:
- MADDR_WIDTH, `DEFAULT_MADDR_WIDTH: memory address width.
- MDATA_WIDTH, `DEFAULT_MDATA_WIDTH: memory data width.
- TIMEOUT, 64: max cycles a grant may wait for a memory ready before forced release.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rq_read_enable  in  2  per-requester read request (bit 0 = Dijkstra, bit 1 = host).
- rq_write_enable  in  2  per-requester write request.
- rq_addr  in  2*MADDR_WIDTH  per-requester address, requester n at slice n.
- rq_write_data  in  2*MDATA_WIDTH  per-requester write data.
- rq_read_ready  out  2  read-complete strobe, routed to the granted requester only.
- rq_write_ready  out  2  write-complete strobe, routed to the granted requester only.
- rq_read_data  out  MDATA_WIDTH  memory read data, broadcast; valid only with rq_read_ready.
- mem_read_enable  out  1  to BlockRam.
- mem_write_enable  out  1  to BlockRam.
- mem_addr  out  MADDR_WIDTH  to BlockRam.
- mem_write_data  out  MDATA_WIDTH  to BlockRam.
- mem_read_ready  in  1  from BlockRam.
- mem_write_ready  in  1  from BlockRam.
- mem_read_data  in  MDATA_WIDTH  from BlockRam.
- grant  out  2  one-hot current owner; 0 when idle.
- timeout_error  out  1  sticky; set on watchdog expiry, cleared only by reset.

Behaviour:
- Reset (async assert, sync release): state IDLE, grant=0, last=1 (requester 0 wins the first tie), all mem_* outputs 0, rq_*_ready=0, rq_read_data=0, timeout_error=0, watchdog=0.
- A requester is pending when its read_enable or write_enable is high.
- IDLE:
  - If exactly one requester is pending, grant it next cycle.
  - If both are pending, grant the one not equal to last.
  - Grant is registered: one cycle of latency from request to grant.
- GRANTED(n):
  - mem_addr, mem_write_data and enables are combinationally muxed from requester n.
  - If n has both enables high, write wins: mem_read_enable=0.
  - mem_read_ready/mem_write_ready are forwarded combinationally to bit n only; the other bit is held 0.
- Release:
  - When requester n drops both enables, go to IDLE on the next edge and set last=n.
  - This gives one mandatory bubble cycle between grants; mem enables are 0 in IDLE.
- No preemption: a pending requester waits however long the owner holds its enables, subject only to the watchdog.
- Watchdog:
  - Counts cycles in GRANTED with no mem_*_ready seen; resets to 0 on any ready.
  - Reaching TIMEOUT sets timeout_error and forces IDLE with last=n.
  - The stuck requester is masked from arbitration until it drops its enables (per-requester mask bit, cleared on drop).
- A requester that keeps its enables high after its ready strobe keeps the grant; this is legal and models the held-enable protocol.
- Reset mid-transaction: outputs return to reset values immediately (asynchronous); BlockRam state is not guaranteed.
- Counter width: $clog2(TIMEOUT+1).

Decomposition:
- Shared package holds:
  - Requester index constants REQ_DIJKSTRA=0, REQ_HOST=1.
  - Arbiter state enum {IDLE, GRANTED}.
  - The DEFAULT_* widths already defined in constants.v.
- One natural sub-module: rr_arbiter2, a two-input round-robin pick with inputs pending, mask and last and one-hot output.

Test Plan:
- Host-only write, addr 0x10, data 5 → grant=2'b10 one cycle later; mem_write_enable=1 with mem_addr=0x10; rq_write_ready[1] pulses with mem_write_ready; rq_write_ready[0] stays 0.
- Both request reads in the same cycle after reset → Dijkstra granted first. After it drops its enables: one IDLE cycle, then host granted. Each requester sees its own data with rq_read_ready.
- Dijkstra issues back-to-back reads while host is pending → grants alternate 01, 00, 10, 00, 01; host is never starved.
- Requester 0 asserts read and write together, addr 0x20 → mem_write_enable=1, mem_read_enable=0.
- BlockRam ready tied low, host requests → after 64 cycles timeout_error=1, grant=0. A pending Dijkstra is then granted and the host stays masked until it drops its enables.
- reset pulled low mid-grant → grant, mem_* and timeout_error are 0 in the same cycle without waiting for a clock edge; after release, the first grant goes to requester 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the BlockRam bus arbiter: requester indices,
// arbiter state encoding, default bus widths and a one-hot helper.
package mem_arbiter_pkg;

  localparam int DEFAULT_MADDR_WIDTH = 16;
  localparam int DEFAULT_MDATA_WIDTH = 32;

  localparam int NUM_REQ      = 2;
  localparam int REQ_DIJKSTRA = 0;
  localparam int REQ_HOST     = 1;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_e;

  // Requester index to one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and BlockRam-side bus of the memory arbiter.
//   master : arbiter view (takes requests, drives the BlockRam port)
//   slave  : environment view (requesters + BlockRam)
// Requester n uses slice/bit n of every rq_* signal.
interface mem_arbiter_if #(
  parameter int MADDR_WIDTH = mem_arbiter_pkg::DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH = mem_arbiter_pkg::DEFAULT_MDATA_WIDTH
);
  import mem_arbiter_pkg::*;

  logic [NUM_REQ-1:0]                  rq_read_enable;
  logic [NUM_REQ-1:0]                  rq_write_enable;
  logic [NUM_REQ-1:0][MADDR_WIDTH-1:0] rq_addr;
  logic [NUM_REQ-1:0][MDATA_WIDTH-1:0] rq_write_data;
  logic [NUM_REQ-1:0]                  rq_read_ready;
  logic [NUM_REQ-1:0]                  rq_write_ready;
  logic [MDATA_WIDTH-1:0]              rq_read_data;

  logic                                mem_read_enable;
  logic                                mem_write_enable;
  logic [MADDR_WIDTH-1:0]              mem_addr;
  logic [MDATA_WIDTH-1:0]              mem_write_data;
  logic                                mem_read_ready;
  logic                                mem_write_ready;
  logic [MDATA_WIDTH-1:0]              mem_read_data;

  modport master (
    input  rq_read_enable, rq_write_enable, rq_addr, rq_write_data,
    input  mem_read_ready, mem_write_ready, mem_read_data,
    output rq_read_ready, rq_write_ready, rq_read_data,
    output mem_read_enable, mem_write_enable, mem_addr, mem_write_data
  );

  modport slave (
    output rq_read_enable, rq_write_enable, rq_addr, rq_write_data,
    output mem_read_ready, mem_write_ready, mem_read_data,
    input  rq_read_ready, rq_write_ready, rq_read_data,
    input  mem_read_enable, mem_write_enable, mem_addr, mem_write_data
  );

endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-input round-robin pick.
//   pending : per-requester request
//   mask    : requesters excluded from arbitration
//   last    : index of the most recent owner; the other one wins a tie
//   pick    : one-hot winner, 0 when nobody is eligible
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] pending,
  input  logic [NUM_REQ-1:0] mask,
  input  logic               last,
  output logic [NUM_REQ-1:0] pick
);

  logic [NUM_REQ-1:0] elig;
  assign elig = pending & ~mask;

  always_comb begin
    pick = '0;
    if (elig[REQ_DIJKSTRA] && elig[REQ_HOST])
      pick = req_onehot(~last);
    else if (elig[REQ_DIJKSTRA])
      pick = req_onehot(1'b0);
    else if (elig[REQ_HOST])
      pick = req_onehot(1'b1);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-port BlockRam bus
// (requester 0 = Dijkstra core, requester 1 = host/graph loader).
// Grant is registered; the owner's request is muxed combinationally onto
// the memory port and memory ready strobes are routed back to it only.
// A watchdog drops an owner that sees no ready for TIMEOUT granted cycles
// and masks it until it lowers its enables.
//   clock, reset  : clock, async active-low reset
//   bus           : requester + BlockRam signals (master modport)
//   grant         : one-hot current owner, 0 when idle
//   timeout_error : sticky watchdog flag, cleared only by reset
module mem_arbiter #(
  parameter int MADDR_WIDTH = mem_arbiter_pkg::DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH = mem_arbiter_pkg::DEFAULT_MDATA_WIDTH,
  parameter int TIMEOUT     = 64
) (
  input  logic               clock,
  input  logic               reset,
  mem_arbiter_if.master      bus,
  output logic [1:0]         grant,
  output logic               timeout_error
);
  import mem_arbiter_pkg::*;

  localparam int WD_W = $clog2(TIMEOUT + 1);

  arb_state_e         state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic [NUM_REQ-1:0] mask_q, mask_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic               terr_d;

  logic [NUM_REQ-1:0] pending, pick;
  logic               mem_rdy;
  logic [MADDR_WIDTH-1:0] sel_addr;
  logic [MDATA_WIDTH-1:0] sel_wdata;

  assign pending = bus.rq_read_enable | bus.rq_write_enable;
  assign mem_rdy = bus.mem_read_ready | bus.mem_write_ready;

  rr_arbiter2 u_rr (
    .pending (pending),
    .mask    (mask_q),
    .last    (last_q),
    .pick    (pick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_q        <= 1'b1;
      mask_q        <= '0;
      wdog_q        <= '0;
      timeout_error <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      mask_q        <= mask_d;
      wdog_q        <= wdog_d;
      timeout_error <= terr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    terr_d  = timeout_error;
    // A mask bit lives only while its requester keeps an enable up.
    mask_d  = mask_q & pending;
    case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (pick != '0) begin
          state_d = GRANTED;
          owner_d = pick[REQ_HOST];
        end
      end
      GRANTED: begin
        if (!pending[owner_q]) begin
          state_d = IDLE;
          last_d  = owner_q;
          wdog_d  = '0;
        end else if (mem_rdy) begin
          wdog_d = '0;
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          // TIMEOUT-th consecutive granted cycle without a ready.
          state_d         = IDLE;
          last_d          = owner_q;
          wdog_d          = '0;
          terr_d          = 1'b1;
          mask_d[owner_q] = 1'b1;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel_addr  = bus.rq_addr[owner_q];
  assign sel_wdata = bus.rq_write_data[owner_q];

  always_comb begin
    grant                = '0;
    bus.mem_read_enable  = 1'b0;
    bus.mem_write_enable = 1'b0;
    bus.mem_addr         = '0;
    bus.mem_write_data   = '0;
    bus.rq_read_ready    = '0;
    bus.rq_write_ready   = '0;
    bus.rq_read_data     = '0;
    if (state_q == GRANTED) begin
      grant                          = req_onehot(owner_q);
      bus.mem_addr                   = sel_addr;
      bus.mem_write_data             = sel_wdata;
      bus.mem_write_enable           = bus.rq_write_enable[owner_q];
      // Write wins when the owner raises both enables.
      bus.mem_read_enable            = bus.rq_read_enable[owner_q] &
                                       ~bus.rq_write_enable[owner_q];
      bus.rq_read_ready[owner_q]     = bus.mem_read_ready;
      bus.rq_write_ready[owner_q]    = bus.mem_write_ready;
      bus.rq_read_data               = bus.mem_read_data;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] grant;
  logic       timeout_error;

  int errors = 0;
  int checks = 0;

  mem_arbiter_if #(.MADDR_WIDTH(AW), .MDATA_WIDTH(DW)) bus ();

  mem_arbiter #(.MADDR_WIDTH(AW), .MDATA_WIDTH(DW), .TIMEOUT(64)) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus),
    .grant         (grant),
    .timeout_error (timeout_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]    rd, wr;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          mrr, mwr;
    logic [DW-1:0] mrdata;
    logic [1:0]    eg;
    logic          emrd, emwr;
    logic [AW-1:0] ema;
    logic [DW-1:0] emwd;
    logic [1:0]    err, ewr;
    logic [DW-1:0] erd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [1:0] rd, wr, input logic [AW-1:0] a0,
                              input logic [DW-1:0] d0, input logic mrr, mwr,
                              input logic [DW-1:0] mrdata, input logic [1:0] eg,
                              input logic emrd, emwr, input logic [AW-1:0] ema,
                              input logic [DW-1:0] emwd, input logic [1:0] err, ewr,
                              input logic [DW-1:0] erd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a0 = a0; v.d0 = d0; v.mrr = mrr; v.mwr = mwr;
    v.mrdata = mrdata; v.eg = eg; v.emrd = emrd; v.emwr = emwr; v.ema = ema;
    v.emwd = emwd; v.err = err; v.ewr = ewr; v.erd = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    bus.rq_read_enable  = '0;
    bus.rq_write_enable = '0;
    bus.rq_addr[0]      = 8'h30;
    bus.rq_addr[1]      = 8'h10;
    bus.rq_write_data[0] = 16'h0;
    bus.rq_write_data[1] = 16'h5;
    bus.mem_read_ready  = 1'b0;
    bus.mem_write_ready = 1'b0;
    bus.mem_read_data   = '0;

    // requester 1 fixed at addr 0x10 / data 5; requester 0 addr/data per row
    // A: host-only write
    tbl.push_back(mk(2'b00,2'b10,8'h30,16'h0,0,0,16'h0,    2'b00,0,0,8'h00,16'h0,2'b00,2'b00,16'h0));
    tbl.push_back(mk(2'b00,2'b10,8'h30,16'h0,0,0,16'h0,    2'b10,0,1,8'h10,16'h5,2'b00,2'b00,16'h0));
    tbl.push_back(mk(2'b00,2'b10,8'h30,16'h0,0,1,16'h0,    2'b10,0,1,8'h10,16'h5,2'b00,2'b10,16'h0));
    tbl.push_back(mk(2'b00,2'b00,8'h30,16'h0,0,0,16'h0,    2'b10,0,0,8'h10,16'h5,2'b00,2'b00,16'h0));
    tbl.push_back(mk(2'b00,2'b00,8'h30,16'h0,0,0,16'h0,    2'b00,0,0,8'h00,16'h0,2'b00,2'b00,16'h0));
    // B: simultaneous reads, Dijkstra first, bubble, then host
    tbl.push_back(mk(2'b11,2'b00,8'h30,16'h0,0,0,16'h0,    2'b00,0,0,8'h00,16'h0,2'b00,2'b00,16'h0));
    tbl.push_back(mk(2'b11,2'b00,8'h30,16'h0,1,0,16'hAAAA, 2'b01,1,0,8'h30,16'h0,2'b01,2'b00,16'hAAAA));
    tbl.push_back(mk(2'b10,2'b00,8'h30,16'h0,0,0,16'h0,    2'b01,0,0,8'h30,16'h0,2'b00,2'b00,16'h0));
    tbl.push_back(mk(2'b10,2'b00,8'h30,16'h0,0,0,16'h0,    2'b00,0,0,8'h00,16'h0,2'b00,2'b00,16'h0));
    tbl.push_back(mk(2'b10,2'b00,8'h30,16'h0,1,0,16'h5555, 2'b10,1,0,8'h10,16'h5,2'b10,2'b00,16'h5555));
    tbl.push_back(mk(2'b00,2'b00,8'h30,16'h0,0,0,16'h0,    2'b10,0,0,8'h10,16'h5,2'b00,2'b00,16'h0));
    // C: back-to-back Dijkstra reads with host pending: 01,00,10,00,01
    tbl.push_back(mk(2'b11,2'b00,8'h30,16'h0,0,0,16'h0,    2'b00,0,0,8'h00,16'h0,2'b00,2'b00,16'h0));
    tbl.push_back(mk(2'b11,2'b00,8'h30,16'h0,1,0,16'h0001, 2'b01,1,0,8'h30,16'h0,2'b01,2'b00,16'h0001));
    tbl.push_back(mk(2'b10,2'b00,8'h30,16'h0,0,0,16'h0,    2'b01,0,0,8'h30,16'h0,2'b00,2'b00,16'h0));
    tbl.push_back(mk(2'b11,2'b00,8'h30,16'h0,0,0,16'h0,    2'b00,0,0,8'h00,16'h0,2'b00,2'b00,16'h0));
    tbl.push_back(mk(2'b11,2'b00,8'h30,16'h0,1,0,16'h0002, 2'b10,1,0,8'h10,16'h5,2'b10,2'b00,16'h0002));
    tbl.push_back(mk(2'b01,2'b00,8'h30,16'h0,0,0,16'h0,    2'b10,0,0,8'h10,16'h5,2'b00,2'b00,16'h0));
    tbl.push_back(mk(2'b01,2'b00,8'h30,16'h0,0,0,16'h0,    2'b00,0,0,8'h00,16'h0,2'b00,2'b00,16'h0));
    tbl.push_back(mk(2'b01,2'b00,8'h30,16'h0,0,0,16'h0,    2'b01,1,0,8'h30,16'h0,2'b00,2'b00,16'h0));
    tbl.push_back(mk(2'b00,2'b00,8'h30,16'h0,0,0,16'h0,    2'b01,0,0,8'h30,16'h0,2'b00,2'b00,16'h0));
    // D: read+write together, write wins
    tbl.push_back(mk(2'b01,2'b01,8'h20,16'h77,0,0,16'h0,   2'b00,0,0,8'h00,16'h0,2'b00,2'b00,16'h0));
    tbl.push_back(mk(2'b01,2'b01,8'h20,16'h77,0,1,16'h0,   2'b01,0,1,8'h20,16'h77,2'b00,2'b01,16'h0));
    tbl.push_back(mk(2'b00,2'b00,8'h20,16'h77,0,0,16'h0,   2'b01,0,0,8'h20,16'h77,2'b00,2'b00,16'h0));
    tbl.push_back(mk(2'b00,2'b00,8'h20,16'h77,0,0,16'h0,   2'b00,0,0,8'h00,16'h0,2'b00,2'b00,16'h0));

    // reset state
    #3;
    chk("rst grant", grant, 2'b00);
    chk("rst terr", timeout_error, 1'b0);
    chk("rst mem_rd", bus.mem_read_enable, 1'b0);
    chk("rst mem_wr", bus.mem_write_enable, 1'b0);
    #4 reset = 1'b1;
    tick();

    foreach (tbl[i]) begin
      bus.rq_read_enable   = tbl[i].rd;
      bus.rq_write_enable  = tbl[i].wr;
      bus.rq_addr[0]       = tbl[i].a0;
      bus.rq_write_data[0] = tbl[i].d0;
      bus.mem_read_ready   = tbl[i].mrr;
      bus.mem_write_ready  = tbl[i].mwr;
      bus.mem_read_data    = tbl[i].mrdata;
      #2;
      chk($sformatf("v%0d grant", i), grant, tbl[i].eg);
      chk($sformatf("v%0d mem_rd", i), bus.mem_read_enable, tbl[i].emrd);
      chk($sformatf("v%0d mem_wr", i), bus.mem_write_enable, tbl[i].emwr);
      chk($sformatf("v%0d mem_addr", i), bus.mem_addr, tbl[i].ema);
      chk($sformatf("v%0d mem_wdata", i), bus.mem_write_data, tbl[i].emwd);
      chk($sformatf("v%0d rq_rrdy", i), bus.rq_read_ready, tbl[i].err);
      chk($sformatf("v%0d rq_wrdy", i), bus.rq_write_ready, tbl[i].ewr);
      chk($sformatf("v%0d rq_rdata", i), bus.rq_read_data, tbl[i].erd);
      tick();
    end

    // Watchdog: host stuck with BlockRam ready low, Dijkstra waiting
    bus.rq_addr[0]       = 8'h30;
    bus.rq_write_data[0] = 16'h0;
    bus.mem_read_ready   = 1'b0;
    bus.mem_write_ready  = 1'b0;
    bus.mem_read_data    = '0;
    bus.rq_read_enable   = 2'b10;
    tick();
    chk("wd grant host", grant, 2'b10);
    bus.rq_read_enable = 2'b11;
    repeat (63) tick();
    chk("wd 63 grant", grant, 2'b10);
    chk("wd 63 terr", timeout_error, 1'b0);
    tick();
    chk("wd 64 terr", timeout_error, 1'b1);
    chk("wd 64 grant", grant, 2'b00);
    tick();
    chk("wd dijkstra grant", grant, 2'b01);
    chk("wd dijkstra mem_rd", bus.mem_read_enable, 1'b1);
    chk("wd dijkstra addr", bus.mem_addr, 8'h30);
    bus.rq_read_enable = 2'b10;
    tick();
    tick();
    tick();
    chk("wd host masked", grant, 2'b00);
    chk("wd terr sticky", timeout_error, 1'b1);
    bus.rq_read_enable = 2'b00;
    tick();
    bus.rq_read_enable = 2'b10;
    tick();
    chk("wd mask cleared", grant, 2'b10);
    chk("wd regrant mem_rd", bus.mem_read_enable, 1'b1);

    // Asynchronous reset mid-grant
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = 16'hFFFF;
    #2 reset = 1'b0;
    #1;
    chk("arst grant", grant, 2'b00);
    chk("arst mem_rd", bus.mem_read_enable, 1'b0);
    chk("arst mem_addr", bus.mem_addr, 8'h00);
    chk("arst terr", timeout_error, 1'b0);
    chk("arst rq_rrdy", bus.rq_read_ready, 2'b00);
    chk("arst rq_rdata", bus.rq_read_data, 16'h0);
    bus.mem_read_ready = 1'b0;
    bus.mem_read_data  = '0;
    bus.rq_read_enable = 2'b11;
    #2 reset = 1'b1;
    tick();
    chk("post-rst grant", grant, 2'b01);
    chk("post-rst terr", timeout_error, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
